// File: rtl/alarm_sequencer_pkg.sv
// Shared encodings for the alarm clock: sequencer and display FSM states, time field widths.
// Latency: n/a (definitions only); backpressure: none.
package alarm_sequencer_pkg;

   localparam int HH_W = 5;
   localparam int MM_W = 6;
   localparam int SS_W = 6;

   localparam int MIN_PER_HOUR = 60;
   localparam int MIN_PER_DAY  = 1440;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RING   = 2'd1;
   localparam logic [1:0] ST_SNOOZE = 2'd2;

   localparam logic [1:0] DISP_TIME   = 2'd0;
   localparam logic [1:0] DISP_ALARM  = 2'd1;
   localparam logic [1:0] DISP_SET_HH = 2'd2;
   localparam logic [1:0] DISP_SET_MM = 2'd3;

   typedef struct packed {
      logic [HH_W-1:0] hh;
      logic [MM_W-1:0] mm;
   } hhmm_t;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone source: output toggles every TONE_DIV cycles while enabled, held low otherwise.
// Latency: tone gated combinationally by en; backpressure: none.
module buzzer_tone_gen #(
   parameter int TONE_DIV = 25000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tone
);

   localparam int DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tone_q, tone_d;

   always_comb begin
      div_d  = div_q;
      tone_d = tone_q;
      if (!en) begin
         div_d  = '0;
         tone_d = 1'b0;
      end else if (div_q == DIV_LAST) begin
         div_d  = '0;
         tone_d = ~tone_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tone_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tone_q <= tone_d;
      end
   end

   // Gating with en silences the piezo the moment ringing stops or an odd second begins.
   assign tone = tone_q & en;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm FSM (idle/ring/snooze) with snooze target tracking, ring timeout and beeping buzzer.
// Latency: status outputs one cycle after the deciding edge; backpressure: none (pulse inputs).
module alarm_sequencer
   import alarm_sequencer_pkg::*;
#(
   parameter int TONE_DIV     = 25000,
   parameter int SNOOZE_MIN   = 5,
   parameter int SNOOZE_MAX   = 3,
   parameter int RING_TIMEOUT = 60
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       TICK_1HZ,
   input  logic [4:0] CUR_HH,
   input  logic [5:0] CUR_MM,
   input  logic [5:0] CUR_SS,
   input  logic [4:0] ALM_HH,
   input  logic [5:0] ALM_MM,
   input  logic       ALM_EN,
   input  logic       STOP_BTN,
   input  logic       SNOOZE_BTN,
   output logic       BUZZER,
   output logic       RINGING,
   output logic       SNOOZED,
   output logic [1:0] SNOOZE_CNT
);

   localparam int RS_W = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT + 1) : 1;
   localparam logic [RS_W-1:0] RS_LIMIT = RS_W'(RING_TIMEOUT);
   localparam logic [1:0]      SNZ_MAX  = 2'(SNOOZE_MAX);

   // Minute-of-day addition with hour carry and midnight wrap.
   function automatic hhmm_t time_add(input hhmm_t t, input logic [11:0] add_min);
      logic [12:0] total;
      logic [12:0] wrapped;
      hhmm_t       r;
      total   = 13'(t.hh) * 13'(MIN_PER_HOUR) + 13'(t.mm) + 13'(add_min);
      wrapped = total % 13'(MIN_PER_DAY);
      r.hh    = HH_W'(wrapped / 13'(MIN_PER_HOUR));
      r.mm    = MM_W'(wrapped % 13'(MIN_PER_HOUR));
      return r;
   endfunction

   logic [1:0]      state_q, state_d;
   logic [1:0]      snooze_cnt_q, snooze_cnt_d;
   logic [RS_W-1:0] ring_sec_q, ring_sec_d;
   hhmm_t           trig_q, trig_d;
   hhmm_t           target_q, target_d;
   logic            ringing_q, ringing_d;
   logic            snoozed_q, snoozed_d;

   logic            at_minute_start;
   logic            alarm_hit;
   logic            snooze_hit;
   logic            cancel_req;
   logic            snooze_ok;
   logic [1:0]      snooze_cnt_inc;
   logic [RS_W-1:0] ring_sec_inc;
   logic            tone_en;

   assign at_minute_start = TICK_1HZ && (CUR_SS == '0);
   assign alarm_hit       = at_minute_start && ALM_EN &&
                            (CUR_HH == ALM_HH) && (CUR_MM == ALM_MM);
   assign snooze_hit      = at_minute_start &&
                            (CUR_HH == target_q.hh) && (CUR_MM == target_q.mm);
   assign cancel_req      = STOP_BTN || !ALM_EN;
   assign snooze_ok       = SNOOZE_BTN && (snooze_cnt_q < SNZ_MAX);
   assign snooze_cnt_inc  = snooze_cnt_q + 2'd1;
   assign ring_sec_inc    = ring_sec_q + RS_W'(1);

   always_comb begin
      state_d      = state_q;
      snooze_cnt_d = snooze_cnt_q;
      ring_sec_d   = ring_sec_q;
      trig_d       = trig_q;
      target_d     = target_q;
      case (state_q)
         ST_IDLE: begin
            if (alarm_hit) begin
               state_d      = ST_RING;
               snooze_cnt_d = 2'd0;
               ring_sec_d   = '0;
               trig_d       = '{hh: ALM_HH, mm: ALM_MM};
            end
         end
         ST_RING: begin
            // Stop outranks snooze when both arrive together.
            if (cancel_req) begin
               state_d    = ST_IDLE;
               ring_sec_d = '0;
            end else if (snooze_ok) begin
               state_d      = ST_SNOOZE;
               snooze_cnt_d = snooze_cnt_inc;
               ring_sec_d   = '0;
               target_d     = time_add(trig_q, 12'(SNOOZE_MIN) * {10'd0, snooze_cnt_inc});
            end else if (TICK_1HZ) begin
               if (ring_sec_inc == RS_LIMIT) begin
                  state_d    = ST_IDLE;
                  ring_sec_d = '0;
               end else begin
                  ring_sec_d = ring_sec_inc;
               end
            end
         end
         ST_SNOOZE: begin
            if (cancel_req) begin
               state_d = ST_IDLE;
            end else if (snooze_hit) begin
               state_d    = ST_RING;
               ring_sec_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ringing_d = (state_d == ST_RING);
      snoozed_d = (state_d == ST_SNOOZE);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q      <= ST_IDLE;
         snooze_cnt_q <= 2'd0;
         ring_sec_q   <= '0;
         trig_q       <= '0;
         target_q     <= '0;
         ringing_q    <= 1'b0;
         snoozed_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         snooze_cnt_q <= snooze_cnt_d;
         ring_sec_q   <= ring_sec_d;
         trig_q       <= trig_d;
         target_q     <= target_d;
         ringing_q    <= ringing_d;
         snoozed_q    <= snoozed_d;
      end
   end

   // Beep on even ring-seconds only.
   assign tone_en = (state_q == ST_RING) && !ring_sec_q[0];

   buzzer_tone_gen #(
      .TONE_DIV(TONE_DIV)
   ) u_tone (
      .clk  (CLK),
      .rst_n(RESETN),
      .en   (tone_en),
      .tone (BUZZER)
   );

   assign RINGING    = ringing_q;
   assign SNOOZED    = snoozed_q;
   assign SNOOZE_CNT = snooze_cnt_q;

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter TONE_DIV, default 25000: CLK cycles per buzzer tone half-period.
REQ-002 Parameter SNOOZE_MIN, default 5: minutes added per snooze.
REQ-003 Parameter SNOOZE_MAX, default 3: snoozes allowed per alarm event.
REQ-004 Parameter RING_TIMEOUT, default 60: seconds of ringing before auto-stop.
REQ-005 CLK  input  1  system clock; one clock; all state on posedge CLK.
REQ-006 RESETN  input  1  asynchronous, active-low reset.
REQ-007 TICK_1HZ  input  1  one-CLK-cycle strobe, once per second.
REQ-008 CUR_HH / CUR_MM / CUR_SS  input  5/6/6  current time, binary (0-23/0-59/0-59).
REQ-009 ALM_HH / ALM_MM  input  5/6  programmed alarm time, binary.
REQ-010 ALM_EN  input  1  alarm armed.
REQ-011 STOP_BTN / SNOOZE_BTN  input  1 each  debounced, one-cycle pulses.
REQ-012 BUZZER  output  1  tone drive to piezo.
REQ-013 RINGING  output  1  high in RING state.
REQ-014 SNOOZED  output  1  high in SNOOZE state.
REQ-015 SNOOZE_CNT  output  2  snoozes used in current event.

Function
REQ-016 FSM states: IDLE, RING, SNOOZE; encoding in shared package.
REQ-017 IDLE->RING when TICK_1HZ & ALM_EN & CUR_HH==ALM_HH & CUR_MM==ALM_MM & CUR_SS==0; SNOOZE_CNT cleared to 0 on this transition.
REQ-018 RING->IDLE on STOP_BTN, on ALM_EN low, or when ring-second counter reaches RING_TIMEOUT.
REQ-019 RING->SNOOZE on SNOOZE_BTN when SNOOZE_CNT<SNOOZE_MAX; SNOOZE_CNT increments; target = trigger time + SNOOZE_MIN*SNOOZE_CNT minutes.
REQ-020 SNOOZE_BTN with SNOOZE_CNT==SNOOZE_MAX is ignored; state stays RING.
REQ-021 Snooze target arithmetic wraps: minutes mod 60 with carry into hours, hours mod 24 (23:58 +5 -> 00:03).
REQ-022 SNOOZE->RING on TICK_1HZ with CUR_HH:CUR_MM equal target and CUR_SS==0; ring-second counter reset to 0.
REQ-023 SNOOZE->IDLE on STOP_BTN or ALM_EN low.
REQ-024 Simultaneous STOP_BTN and SNOOZE_BTN: STOP wins.
REQ-025 Ring-second counter increments on TICK_1HZ only in RING; cleared on every entry to RING.
REQ-026 BUZZER beep pattern: in RING, tone active during even ring-seconds, silent during odd; tone = square wave toggling every TONE_DIV CLK cycles.
REQ-027 BUZZER is 0 in IDLE and SNOOZE and in the cycle after leaving RING; tone divider cleared when not RING.
REQ-028 RINGING/SNOOZED are registered decodes of state, valid the cycle after transition.
REQ-029 ALM_HH/ALM_MM changes during SNOOZE do not alter the latched target.

Reset
REQ-030 RESETN low asynchronously forces: state IDLE, BUZZER 0, RINGING 0, SNOOZED 0, SNOOZE_CNT 0, counters and target 0.
REQ-031 Reset asserted mid-ring silences BUZZER immediately, without waiting for CLK.
REQ-032 After release, no trigger occurs until a fresh TICK_1HZ matching condition.

Structure
REQ-033 Shared package/include holds state encodings and time widths (HH 5, MM/SS 6), alongside the display FSM state constants.
REQ-034 Tone generator (divider + square wave, enable input) SHALL be a sub-module named buzzer_tone_gen.
REQ-035 Time-add (minutes with carry, 24 h wrap) SHALL be a combinational function inside alarm_sequencer.

Verification
REQ-036 ALM 07:30, EN=1, time 07:29:59 -> 07:30:00 tick -> RINGING=1 next cycle; BUZZER toggles every TONE_DIV cycles in second 0, silent in second 1.
REQ-037 Ringing, SNOOZE_BTN -> SNOOZED=1, SNOOZE_CNT=1; time reaches 07:35:00 -> RINGING=1; three snoozes used -> fourth SNOOZE_BTN ignored.
REQ-038 ALM 23:58, snooze once -> re-ring at 00:03:00.
REQ-039 Ringing with no input -> after 60 ticks state IDLE, BUZZER 0; STOP_BTN+SNOOZE_BTN same cycle -> IDLE.
REQ-040 RESETN pulled low mid-tone between clock edges -> BUZZER 0 same instant; matching time with ALM_EN=0 -> stays IDLE.
